// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I load/store funct3 codes, FSM states
// and access-size helpers used by both the unit and its alignment datapath.
package load_store_unit_pkg;

    localparam logic [2:0] LS_FUNCT3_B  = 3'b000;
    localparam logic [2:0] LS_FUNCT3_H  = 3'b001;
    localparam logic [2:0] LS_FUNCT3_W  = 3'b010;
    localparam logic [2:0] LS_FUNCT3_BU = 3'b100;
    localparam logic [2:0] LS_FUNCT3_HU = 3'b101;

    typedef enum logic [2:0] {
        LS_IDLE,
        LS_RD_ADDR,
        LS_RD_DATA,
        LS_WR_REQ,
        LS_WR_RESP,
        LS_MIS_WAIT,
        LS_DONE
    } ls_state_e;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W
    } ls_size_e;

    // Any funct3 outside the five load/store encodings is treated as a word access.
    function automatic ls_size_e decode_size(input logic [2:0] funct3);
        case (funct3)
            LS_FUNCT3_B, LS_FUNCT3_BU: decode_size = SIZE_B;
            LS_FUNCT3_H, LS_FUNCT3_HU: decode_size = SIZE_H;
            LS_FUNCT3_W:               decode_size = SIZE_W;
            default:                   decode_size = SIZE_W;
        endcase
    endfunction

    function automatic logic [1:0] align_offset(input ls_size_e size, input logic [1:0] offset);
        case (size)
            SIZE_B:  align_offset = offset;
            SIZE_H:  align_offset = {offset[1], 1'b0};
            default: align_offset = 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input ls_size_e size, input logic [1:0] offset);
        case (size)
            SIZE_B:  is_misaligned = 1'b0;
            SIZE_H:  is_misaligned = offset[0];
            default: is_misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane datapath: replicates store data across lanes with matching
// strobes, and extracts plus sign/zero-extends load data from a bus word.
module load_store_align
    import load_store_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            offset,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] load_word,
    output logic [STRB_WIDTH-1:0] strobe,
    output logic [DATA_WIDTH-1:0] lane_data,
    output logic [DATA_WIDTH-1:0] load_data
);

    ls_size_e              size;
    logic [DATA_WIDTH-1:0] shifted;

    assign size    = decode_size(funct3);
    assign shifted = load_word >> {offset, 3'b000};

    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            localparam logic       HALF = LANE[1];

            // Bytes repeat in every lane and halfwords in every half, so the strobe alone picks the target.
            assign lane_data[gi*8 +: 8] = (size == SIZE_B) ? store_data[7:0] :
                                          (size == SIZE_H) ? store_data[(gi%2)*8 +: 8] :
                                                             store_data[gi*8 +: 8];
            assign strobe[gi] = (size == SIZE_B) ? (offset == LANE) :
                                (size == SIZE_H) ? (offset[1] == HALF) :
                                                   1'b1;
        end
    endgenerate

    // funct3[2] marks the unsigned variants (BU/HU).
    always_comb begin
        load_data = shifted;
        case (size)
            SIZE_B:  load_data = {{(DATA_WIDTH-8){shifted[7] & ~funct3[2]}}, shifted[7:0]};
            SIZE_H:  load_data = {{(DATA_WIDTH-16){shifted[15] & ~funct3[2]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one load or store at a time over valid/ready read and write channels.
// Optional LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of forcing alignment.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ls_start,
    input  logic                  ls_store,
    input  logic [2:0]            ls_funct3,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_busy,
    output logic                  ls_done,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic                  dr_addr_valid,
    input  logic                  dr_addr_ready,
    output logic [ADDR_WIDTH-1:0] dr_addr,
    input  logic                  dr_data_valid,
    output logic                  dr_data_ready,
    input  logic [DATA_WIDTH-1:0] dr_data,
    output logic                  dw_req_valid,
    input  logic                  dw_req_ready,
    output logic [ADDR_WIDTH-1:0] dw_addr,
    output logic [DATA_WIDTH-1:0] dw_data,
    output logic [STRB_WIDTH-1:0] dw_strobe,
    input  logic                  dw_resp_valid,
    output logic                  dw_resp_ready
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                  ls_misaligned
`endif
);

    ls_state_e             state_reg;
    ls_state_e             state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [1:0]            offset_reg;
    logic [2:0]            funct3_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [STRB_WIDTH-1:0] strobe;
    logic [DATA_WIDTH-1:0] lane_data;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  start_accept;
    ls_size_e              start_size;

    assign start_size   = decode_size(ls_funct3);
    assign start_accept = (state_reg == LS_IDLE) && ls_start;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned_now;
    logic mis_reg;

    assign misaligned_now = is_misaligned(start_size, ls_addr[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_reg <= 1'b0;
        end else if (start_accept) begin
            mis_reg <= misaligned_now;
        end
    end
`endif

    load_store_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_align (
        .funct3     (funct3_reg),
        .offset     (offset_reg),
        .store_data (wdata_reg),
        .load_word  (dr_data),
        .strobe     (strobe),
        .lane_data  (lane_data),
        .load_data  (load_data)
    );

    // Request fields are frozen at acceptance so the core may move on while the bus stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= LS_IDLE;
            addr_reg   <= '0;
            offset_reg <= 2'b00;
            funct3_reg <= 3'b000;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (start_accept) begin
                addr_reg   <= {ls_addr[ADDR_WIDTH-1:2], 2'b00};
                offset_reg <= align_offset(start_size, ls_addr[1:0]);
                funct3_reg <= ls_funct3;
                wdata_reg  <= ls_wdata;
            end
            if ((state_reg == LS_RD_DATA) && dr_data_valid) begin
                rdata_reg <= load_data;
            end
        end
    end

    assign ls_rdata = rdata_reg;
    assign dr_addr  = addr_reg;
    assign dw_addr  = addr_reg;

    always_comb begin
        state_next    = state_reg;
        ls_busy       = (state_reg != LS_IDLE);
        ls_done       = 1'b0;
        dr_addr_valid = 1'b0;
        dr_data_ready = 1'b0;
        dw_req_valid  = 1'b0;
        dw_resp_ready = 1'b0;
        dw_data       = '0;
        dw_strobe     = '0;
`ifdef LSU_MISALIGN_TRAP_EN
        ls_misaligned = 1'b0;
`endif
        case (state_reg)
            LS_IDLE: begin
                if (ls_start) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned_now) state_next = LS_MIS_WAIT;
                    else
`endif
                    state_next = ls_store ? LS_WR_REQ : LS_RD_ADDR;
                end
            end
            LS_RD_ADDR: begin
                dr_addr_valid = 1'b1;
                if (dr_addr_ready) state_next = LS_RD_DATA;
            end
            LS_RD_DATA: begin
                dr_data_ready = 1'b1;
                if (dr_data_valid) state_next = LS_DONE;
            end
            LS_WR_REQ: begin
                dw_req_valid = 1'b1;
                dw_data      = lane_data;
                dw_strobe    = strobe;
                if (dw_req_ready) state_next = LS_WR_RESP;
            end
            LS_WR_RESP: begin
                dw_resp_ready = 1'b1;
                if (dw_resp_valid) state_next = LS_DONE;
            end
            LS_MIS_WAIT: begin
                state_next = LS_DONE;
            end
            LS_DONE: begin
                ls_done    = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                ls_misaligned = mis_reg;
`endif
                state_next = LS_IDLE;
            end
            default: begin
                state_next = LS_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized loads/stores
// against a byte-array memory model, with a bus responder that inserts stalls.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        ls_start;
    logic        ls_store;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_busy;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        dr_addr_valid;
    logic        dr_addr_ready;
    logic [31:0] dr_addr;
    logic        dr_data_valid;
    logic        dr_data_ready;
    logic [31:0] dr_data;
    logic        dw_req_valid;
    logic        dw_req_ready;
    logic [31:0] dw_addr;
    logic [31:0] dw_data;
    logic [3:0]  dw_strobe;
    logic        dw_resp_valid;
    logic        dw_resp_ready;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        ls_misaligned;
`endif

    int          checks;
    int          failures;
    int          txn_count;
    logic [31:0] last_rdata;
    logic [31:0] bus_mem [0:63];
    logic [7:0]  ref_mem [0:255];
    logic [2:0]  f3_tbl  [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    load_store_unit dut (
        .clk           (clk),
        .rst           (rst),
        .ls_start      (ls_start),
        .ls_store      (ls_store),
        .ls_funct3     (ls_funct3),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_busy       (ls_busy),
        .ls_done       (ls_done),
        .ls_rdata      (ls_rdata),
        .dr_addr_valid (dr_addr_valid),
        .dr_addr_ready (dr_addr_ready),
        .dr_addr       (dr_addr),
        .dr_data_valid (dr_data_valid),
        .dr_data_ready (dr_data_ready),
        .dr_data       (dr_data),
        .dw_req_valid  (dw_req_valid),
        .dw_req_ready  (dw_req_ready),
        .dw_addr       (dw_addr),
        .dw_data       (dw_data),
        .dw_strobe     (dw_strobe),
        .dw_resp_valid (dw_resp_valid),
        .dw_resp_ready (dw_resp_ready)
`ifdef LSU_MISALIGN_TRAP_EN
        ,
        .ls_misaligned (ls_misaligned)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic int eff_off(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = int'(a[1:0]);
        if (size_of(f3) == 1) return off;
        if (size_of(f3) == 2) return off & 2;
        return 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int         p;
        logic [7:0] b0;
        logic [7:0] b1;
        p  = int'(a[7:0] & 8'hFC) + eff_off(f3, a);
        b0 = ref_mem[p];
        b1 = ref_mem[p+1];
        case (f3)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd4:    return {24'h0, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd5:    return {16'h0, b1, b0};
            default: return {ref_mem[p+3], ref_mem[p+2], b1, b0};
        endcase
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] val);
        bus_mem[a[7:2]] = val;
        for (int i = 0; i < 4; i++) ref_mem[int'({a[7:2], 2'b00}) + i] = val[8*i +: 8];
    endtask

    task automatic scramble_inputs(input bit poke);
        ls_start  = poke;
        ls_store  = 1'($urandom);
        ls_funct3 = 3'($urandom);
        ls_addr   = $urandom;
        ls_wdata  = $urandom;
    endtask

    // Drives one request, plays the bus side with the given stall counts, and checks every cycle.
    task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int a_stall, input int d_stall, input bit poke);
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_rd;
        logic [3:0]  exp_strb;
        int          sz;
        int          eoff;
        int          base;
        sz       = size_of(f3);
        eoff     = eff_off(f3, addr);
        base     = int'(addr[7:0] & 8'hFC);
        exp_addr = addr & 32'hFFFF_FFFC;
        txn_count++;
        $display("txn %0d %s f3=%0d addr=%h wdata=%h stalls=%0d/%0d poke=%0d",
                 txn_count, st ? "ST" : "LD", f3, addr, wd, a_stall, d_stall, poke);
        @(negedge clk);
        ls_start  = 1'b1;
        ls_store  = st;
        ls_funct3 = f3;
        ls_addr   = addr;
        ls_wdata  = wd;
        @(negedge clk);
        scramble_inputs(poke);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00)) begin
            check("mis_no_bus", 32'({dr_addr_valid, dw_req_valid}), 32'd0);
            check("mis_busy", 32'(ls_busy), 32'd1);
            check("mis_done_early", 32'(ls_done), 32'd0);
            @(negedge clk);
            check("mis_done", 32'(ls_done), 32'd1);
            check("mis_flag", 32'(ls_misaligned), 32'd1);
            check("mis_rdata_held", ls_rdata, last_rdata);
            @(negedge clk);
            ls_start = 1'b0;
            check("mis_idle", 32'(ls_busy), 32'd0);
            return;
        end
`endif
        for (int n = 0; n <= a_stall; n++) begin
            if (n > 0) @(negedge clk);
            if (st) begin
                exp_strb = 4'(((1 << sz) - 1) << eoff);
                exp_data = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
                check("wr_valid", 32'(dw_req_valid), 32'd1);
                check("wr_addr", dw_addr, exp_addr);
                check("wr_strobe", 32'(dw_strobe), 32'(exp_strb));
                check("wr_data", dw_data, exp_data);
                check("wr_resp_ready_early", 32'(dw_resp_ready), 32'd0);
                check("wr_no_read", 32'(dr_addr_valid), 32'd0);
                dw_req_ready = (n == a_stall);
                if (n == a_stall) begin
                    for (int i = 0; i < 4; i++)
                        if (dw_strobe[i]) bus_mem[dw_addr[7:2]][8*i +: 8] = dw_data[8*i +: 8];
                end
            end else begin
                check("rd_valid", 32'(dr_addr_valid), 32'd1);
                check("rd_addr", dr_addr, exp_addr);
                check("rd_dready_early", 32'(dr_data_ready), 32'd0);
                check("rd_no_write", 32'(dw_req_valid), 32'd0);
                dr_addr_ready = (n == a_stall);
            end
            check("busy", 32'(ls_busy), 32'd1);
            check("done_early", 32'(ls_done), 32'd0);
            scramble_inputs(poke);
        end
        for (int n = 0; n <= d_stall; n++) begin
            @(negedge clk);
            dr_addr_ready = 1'b0;
            dw_req_ready  = 1'b0;
            check("busy_wait", 32'(ls_busy), 32'd1);
            check("done_wait", 32'(ls_done), 32'd0);
            if (st) begin
                check("wr_valid_drop", 32'(dw_req_valid), 32'd0);
                check("wr_resp_ready", 32'(dw_resp_ready), 32'd1);
                dw_resp_valid = (n == d_stall);
            end else begin
                check("rd_valid_drop", 32'(dr_addr_valid), 32'd0);
                check("rd_dready", 32'(dr_data_ready), 32'd1);
                dr_data_valid = (n == d_stall);
                dr_data       = dr_data_valid ? bus_mem[exp_addr[7:2]] : $urandom;
            end
            scramble_inputs(poke);
        end
        @(negedge clk);
        dr_data_valid = 1'b0;
        dw_resp_valid = 1'b0;
        check("done", 32'(ls_done), 32'd1);
`ifdef LSU_MISALIGN_TRAP_EN
        check("no_mis_flag", 32'(ls_misaligned), 32'd0);
`endif
        if (st) begin
            for (int i = 0; i < sz; i++) ref_mem[base + eoff + i] = wd[8*i +: 8];
        end else begin
            exp_rd = model_load(f3, addr);
            check("rdata", ls_rdata, exp_rd);
            last_rdata = exp_rd;
        end
        scramble_inputs(poke);
        @(negedge clk);
        ls_start = 1'b0;
        check("idle_busy", 32'(ls_busy), 32'd0);
        check("idle_done", 32'(ls_done), 32'd0);
        check("idle_no_bus", 32'({dr_addr_valid, dw_req_valid}), 32'd0);
        check("rdata_held", ls_rdata, last_rdata);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        txn_count = 0;
        last_rdata = 32'h0;
        rst = 1'b0;
        ls_start = 1'b0;
        ls_store = 1'b0;
        ls_funct3 = 3'd0;
        ls_addr = 32'h0;
        ls_wdata = 32'h0;
        dr_addr_ready = 1'b0;
        dr_data_valid = 1'b0;
        dr_data = 32'h0;
        dw_req_ready = 1'b0;
        dw_resp_valid = 1'b0;
        for (int w = 0; w < 64; w++) set_word(32'(w * 4), $urandom);

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(ls_busy), 32'd0);
        check("rst_done", 32'(ls_done), 32'd0);
        check("rst_rdata", ls_rdata, 32'd0);
        check("rst_valids", 32'({dr_addr_valid, dw_req_valid}), 32'd0);
        check("rst_readies", 32'({dr_data_ready, dw_resp_ready}), 32'd0);
        check("rst_dr_addr", dr_addr, 32'd0);
        check("rst_dw_addr", dw_addr, 32'd0);
        check("rst_dw_data", dw_data, 32'd0);
        check("rst_dw_strobe", 32'(dw_strobe), 32'd0);
        rst = 1'b1;

        set_word(32'h100, 32'hDEADBEEF);
        run_txn(1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 1'b0);
        check("lw_const", ls_rdata, 32'hDEADBEEF);
        set_word(32'h100, 32'h80FF_0000);
        run_txn(1'b0, 3'd0, 32'h103, 32'h0, 0, 0, 1'b0);
        check("lb_const", ls_rdata, 32'hFFFFFF80);
        run_txn(1'b0, 3'd4, 32'h103, 32'h0, 0, 0, 1'b0);
        check("lbu_const", ls_rdata, 32'h00000080);
        run_txn(1'b0, 3'd5, 32'h102, 32'h0, 0, 0, 1'b0);
        check("lhu_const", ls_rdata, 32'h000080FF);
        run_txn(1'b1, 3'd0, 32'h201, 32'h12345678, 0, 0, 1'b0);
        run_txn(1'b0, 3'd2, 32'h200, 32'h0, 0, 0, 1'b0);
        run_txn(1'b0, 3'd2, 32'h104, 32'h0, 5, 3, 1'b1);
        run_txn(1'b0, 3'd2, 32'h102, 32'h0, 0, 0, 1'b0);
        run_txn(1'b1, 3'd1, 32'h0AB, 32'hA5A5_C3D2, 1, 2, 1'b1);

        // Reset while waiting for read data abandons the access immediately.
        @(negedge clk);
        ls_start = 1'b1; ls_store = 1'b0; ls_funct3 = 3'd2; ls_addr = 32'h108;
        @(negedge clk);
        ls_start = 1'b0; dr_addr_ready = 1'b1;
        @(negedge clk);
        dr_addr_ready = 1'b0;
        check("pre_rst_dready", 32'(dr_data_ready), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_valids", 32'({dr_addr_valid, dw_req_valid}), 32'd0);
        check("mid_rst_readies", 32'({dr_data_ready, dw_resp_ready}), 32'd0);
        check("mid_rst_busy", 32'(ls_busy), 32'd0);
        check("mid_rst_done", 32'(ls_done), 32'd0);
        @(negedge clk);
        check("mid_rst_no_done", 32'(ls_done), 32'd0);
        rst = 1'b1;
        last_rdata = 32'h0;
        @(negedge clk);
        check("post_rst_done", 32'(ls_done), 32'd0);
        check("post_rst_idle", 32'(ls_busy), 32'd0);
        run_txn(1'b0, 3'd2, 32'h108, 32'h0, 0, 1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            run_txn(1'($urandom), f3_tbl[$urandom_range(0, 7)], $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
